// File: rtl/slave_cfg_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// cfg_seq_pkg
// Shared types and constants for the slave configuration sequencer.
//   state_t      : sequencer FSM states
//   NUM_REGS     : number of slave registers written per request
//   REG_*        : slave register indices (REG_CMD is written last and acts
//                  as the trigger for the downstream block)
//   cnt_preload  : converts a cycle count into the load value of a
//                  down-counter that signals rollover on its final cycle
// -----------------------------------------------------------------------------
package cfg_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_WRITE = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam int NUM_REGS = 4;

    localparam logic [1:0] REG_BASE = 2'd0;
    localparam logic [1:0] REG_LEN  = 2'd1;
    localparam logic [1:0] REG_MODE = 2'd2;
    localparam logic [1:0] REG_CMD  = 2'd3;

    // A state lasting cyc cycles loads cyc-1 and leaves when the count hits 0.
    function automatic logic [3:0] cnt_preload(input int cyc);
        return (cyc > 0) ? 4'(cyc - 1) : 4'd0;
    endfunction

endpackage

// File: rtl/slave_cfg_sequencer_if.sv
// -----------------------------------------------------------------------------
// slave_cfg_sequencer_if
// Request handshake plus Avalon-MM write-only slave bus of the sequencer.
//   req_valid/req_ready            : request handshake
//   req_base/len/mode/cmd          : words for slave registers 0..3
//   slave_chipselect/write/address/writedata : downstream Avalon-MM bus
// Modports:
//   master : request source (drives req_*, observes everything else)
//   slave  : the sequencer (accepts req_*, drives req_ready and slave_*)
// -----------------------------------------------------------------------------
interface slave_cfg_sequencer_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_base;
    logic [31:0] req_len;
    logic [31:0] req_mode;
    logic [31:0] req_cmd;
    logic        slave_chipselect;
    logic        slave_write;
    logic [2:0]  slave_address;
    logic [31:0] slave_writedata;

    modport master (
        output req_valid, req_base, req_len, req_mode, req_cmd,
        input  req_ready, slave_chipselect, slave_write, slave_address, slave_writedata
    );

    modport slave (
        input  req_valid, req_base, req_len, req_mode, req_cmd,
        output req_ready, slave_chipselect, slave_write, slave_address, slave_writedata
    );
endinterface

// File: rtl/slave_cfg_sequencer_flex_counter.sv
// -----------------------------------------------------------------------------
// flex_counter
// Loadable 4-bit down-counter with rollover flag.
//   clk        : clock
//   reset      : synchronous active-high reset (count -> 0)
//   i_load     : load i_load_val (has priority over i_en)
//   i_load_val : value to load
//   i_en       : decrement by one (wraps 0 -> 15)
//   o_rollover : count is zero, i.e. this is the last cycle of the interval
// -----------------------------------------------------------------------------
module flex_counter (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_load,
    input  logic [3:0] i_load_val,
    input  logic       i_en,
    output logic       o_rollover
);

    logic [3:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= 4'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en) begin
            r_count <= r_count - 4'd1;
        end
    end

    assign o_rollover = (r_count == 4'd0);

endmodule

// File: rtl/slave_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// slave_cfg_sequencer
// Accepts a four-word request and writes the words to slave registers 0..3
// over an Avalon-MM bus: each register gets SETUP_CYC cycles of address/data
// setup followed by a one-cycle write strobe. Chipselect stays high from the
// first setup cycle to the last write, then GAP_CYC idle cycles follow.
// Ports:
//   clk, reset     : clock, synchronous active-high reset
//   bus            : request handshake + Avalon-MM bus (slave modport)
//   o_busy         : FSM is not idle
//   o_seq_done     : one-cycle pulse in the first idle cycle after a request
//   o_done_count   : completed requests, wraps at 16 bits
// Parameters: SETUP_CYC (0..15), GAP_CYC (0..15)
// -----------------------------------------------------------------------------
module slave_cfg_sequencer
    import cfg_seq_pkg::*;
#(
    parameter int SETUP_CYC = 1,
    parameter int GAP_CYC   = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    slave_cfg_sequencer_if.slave bus,
    output logic                 o_busy,
    output logic                 o_seq_done,
    output logic [15:0]          o_done_count
);

    localparam logic [3:0] SETUP_LOAD = cnt_preload(SETUP_CYC);
    localparam logic [3:0] GAP_LOAD   = cnt_preload(GAP_CYC);

    state_t      r_state;
    logic [1:0]  r_idx;
    logic [31:0] r_hold [NUM_REGS];
    logic        r_ready;
    logic        r_busy;
    logic        r_cs;
    logic        r_wr;
    logic [2:0]  r_addr;
    logic [31:0] r_wdata;
    logic        r_done;
    logic [15:0] r_done_cnt;

    logic        w_setup_roll;
    logic        w_gap_roll;
    logic [1:0]  w_idx_next;

    assign w_idx_next = r_idx + 2'd1;

    // Counters reload continuously outside their state, so they hold the
    // full interval on entry and count down only while the state is active.
    flex_counter u_setup_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (r_state != ST_SETUP),
        .i_load_val (SETUP_LOAD),
        .i_en       (r_state == ST_SETUP),
        .o_rollover (w_setup_roll)
    );

    flex_counter u_gap_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (r_state != ST_GAP),
        .i_load_val (GAP_LOAD),
        .i_en       (r_state == ST_GAP),
        .o_rollover (w_gap_roll)
    );

    // All outputs are registered and set on the edge that enters the state
    // they belong to, so they line up with r_state cycle for cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_idx      <= REG_BASE;
            for (int i = 0; i < NUM_REGS; i++) r_hold[i] <= 32'd0;
            r_ready    <= 1'b1;
            r_busy     <= 1'b0;
            r_cs       <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= 3'd0;
            r_wdata    <= 32'd0;
            r_done     <= 1'b0;
            r_done_cnt <= 16'd0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_hold[REG_BASE] <= bus.req_base;
                        r_hold[REG_LEN]  <= bus.req_len;
                        r_hold[REG_MODE] <= bus.req_mode;
                        r_hold[REG_CMD]  <= bus.req_cmd;
                        r_idx   <= REG_BASE;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cs    <= 1'b1;
                        r_addr  <= {1'b0, REG_BASE};
                        r_wdata <= bus.req_base;
                        if (SETUP_CYC == 0) begin
                            r_state <= ST_WRITE;
                            r_wr    <= 1'b1;
                        end else begin
                            r_state <= ST_SETUP;
                        end
                    end
                end
                ST_SETUP: begin
                    if (w_setup_roll) begin
                        r_state <= ST_WRITE;
                        r_wr    <= 1'b1;
                    end
                end
                ST_WRITE: begin
                    if (r_idx != REG_CMD) begin
                        r_idx   <= w_idx_next;
                        r_addr  <= {1'b0, w_idx_next};
                        r_wdata <= r_hold[w_idx_next];
                        if (SETUP_CYC == 0) begin
                            r_wr <= 1'b1;   // next register strobes immediately
                        end else begin
                            r_wr    <= 1'b0;
                            r_state <= ST_SETUP;
                        end
                    end else begin
                        r_idx   <= REG_BASE;
                        r_cs    <= 1'b0;
                        r_wr    <= 1'b0;
                        r_addr  <= 3'd0;
                        r_wdata <= 32'd0;
                        if (GAP_CYC == 0) begin
                            r_state    <= ST_IDLE;
                            r_ready    <= 1'b1;
                            r_busy     <= 1'b0;
                            r_done     <= 1'b1;
                            r_done_cnt <= r_done_cnt + 16'd1;
                        end else begin
                            r_state <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (w_gap_roll) begin
                        r_state    <= ST_IDLE;
                        r_ready    <= 1'b1;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_done_cnt <= r_done_cnt + 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.req_ready        = r_ready;
    assign bus.slave_chipselect = r_cs;
    assign bus.slave_write      = r_wr;
    assign bus.slave_address    = r_addr;
    assign bus.slave_writedata  = r_wdata;
    assign o_busy               = r_busy;
    assign o_seq_done           = r_done;
    assign o_done_count         = r_done_cnt;

endmodule

// File: tb/tb_slave_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// tb_slave_cfg_sequencer
// Two sequencer instances: A (SETUP_CYC=1, GAP_CYC=4) and B (SETUP_CYC=0,
// GAP_CYC=0). Directed table, multi-cycle corner sequences, then random
// requests against a timeline model derived from request offsets.
// -----------------------------------------------------------------------------
module tb_slave_cfg_sequencer;

    localparam int SA = 1, GA = 4;
    localparam int SB = 0, GB = 0;

    logic        clk;
    logic        rst_a, rst_b;
    logic        busy_a, done_a, busy_b, done_b;
    logic [15:0] cnt_a, cnt_b;

    slave_cfg_sequencer_if ifa ();
    slave_cfg_sequencer_if ifb ();

    slave_cfg_sequencer #(.SETUP_CYC(SA), .GAP_CYC(GA)) dut_a (
        .clk(clk), .reset(rst_a), .bus(ifa.slave),
        .o_busy(busy_a), .o_seq_done(done_a), .o_done_count(cnt_a)
    );

    slave_cfg_sequencer #(.SETUP_CYC(SB), .GAP_CYC(GB)) dut_b (
        .clk(clk), .reset(rst_b), .bus(ifb.slave),
        .o_busy(busy_b), .o_seq_done(done_b), .o_done_count(cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        bit        valid;   // req_valid driven after this cycle's check
        bit        cs;
        bit        wr;
        bit [2:0]  addr;
        bit [31:0] data;
        bit        busy;
        bit        done;
        bit [15:0] cnt;
    } vec_t;

    function automatic vec_t mkv(bit v, bit cs, bit wr, int a, int d, bit b, bit dn, int c);
        vec_t r;
        r.valid = v; r.cs = cs; r.wr = wr; r.addr = 3'(a); r.data = 32'(d);
        r.busy = b; r.done = dn; r.cnt = 16'(c);
        return r;
    endfunction

    // {ready, busy, done, cs, wr, addr, data}
    function automatic logic [39:0] pk(bit rdy, bit b, bit dn, bit cs, bit wr,
                                       logic [2:0] a, logic [31:0] d);
        return {rdy, b, dn, cs, wr, a, d};
    endfunction

    function automatic logic [39:0] obs(bit sel);
        if (!sel)
            return {ifa.req_ready, busy_a, done_a, ifa.slave_chipselect,
                    ifa.slave_write, ifa.slave_address, ifa.slave_writedata};
        return {ifb.req_ready, busy_b, done_b, ifb.slave_chipselect,
                ifb.slave_write, ifb.slave_address, ifb.slave_writedata};
    endfunction

    function automatic logic [15:0] obs_cnt(bit sel);
        return sel ? cnt_b : cnt_a;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic drive(bit sel, bit v, logic [31:0] w0, logic [31:0] w1,
                         logic [31:0] w2, logic [31:0] w3);
        if (!sel) begin
            ifa.req_valid = v; ifa.req_base = w0; ifa.req_len = w1;
            ifa.req_mode = w2; ifa.req_cmd = w3;
        end else begin
            ifb.req_valid = v; ifb.req_base = w0; ifb.req_len = w1;
            ifb.req_mode = w2; ifb.req_cmd = w3;
        end
    endtask

    // Expected outputs for a cycle 'off' cycles after the accept edge
    // (off = 1 is the first busy cycle). Each register occupies setup+1
    // cycles, the strobe being the last of them; the gap follows.
    function automatic logic [39:0] ref_out(int setup, bit active, int off, bit dn,
                                            logic [3:0][31:0] w);
        int per, idx, ph;
        if (!active) return pk(1'b1, 1'b0, dn, 1'b0, 1'b0, 3'd0, 32'd0);
        per = setup + 1;
        if (off <= 4 * per) begin
            idx = (off - 1) / per;
            ph  = (off - 1) % per;
            return pk(1'b0, 1'b1, 1'b0, 1'b1, (ph == setup), 3'(idx), w[idx]);
        end
        return pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0);
    endfunction

    task automatic run_random(bit sel, int setup, int gap, int ncyc);
        bit               act = 1'b0;
        bit               dn  = 1'b0;
        int               off = 0;
        int               ntx = 0;
        logic [15:0]      mcnt = 16'd0;
        logic [3:0][31:0] mw = '0;
        logic [3:0][31:0] nw;
        bit               v;
        int               busy_len = 4 * (setup + 1) + gap;
        drive(sel, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        if (!sel) rst_a = 1'b1; else rst_b = 1'b1;
        @(negedge clk);
        @(negedge clk);
        if (!sel) rst_a = 1'b0; else rst_b = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            check($sformatf("rnd%0d_c%0d_out", sel, c), 64'(obs(sel)),
                  64'(ref_out(setup, act, off, dn, mw)));
            check($sformatf("rnd%0d_c%0d_cnt", sel, c), 64'(obs_cnt(sel)), 64'(mcnt));
            v = ($urandom_range(0, 1) == 1);
            for (int k = 0; k < 4; k++) nw[k] = $urandom;
            drive(sel, v, nw[0], nw[1], nw[2], nw[3]);
            if (!act && v) begin
                act = 1'b1; off = 1; dn = 1'b0; mw = nw; ntx++;
                $display("rnd dut%0d txn %0d: %h %h %h %h", sel, ntx,
                         nw[0], nw[1], nw[2], nw[3]);
            end else if (act) begin
                off++;
                if (off > busy_len) begin
                    act = 1'b0; dn = 1'b1; mcnt = mcnt + 16'd1;
                end else begin
                    dn = 1'b0;
                end
            end else begin
                dn = 1'b0;
            end
            @(negedge clk);
        end
        drive(sel, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t        tv [13];
        int          w3cnt;
        int          busy_cyc, dones;
        bit          after_first;
        bit          got;
        logic [31:0] wq [$];
        logic [31:0] exp_w [8];
        logic [31:0] bw [4];

        tv[0]  = mkv(1'b1, 1'b1, 1'b0, 0, 0,   1'b1, 1'b0, 0);
        tv[1]  = mkv(1'b1, 1'b1, 1'b1, 0, 0,   1'b1, 1'b0, 0);
        tv[2]  = mkv(1'b1, 1'b1, 1'b0, 1, 584, 1'b1, 1'b0, 0);
        tv[3]  = mkv(1'b1, 1'b1, 1'b1, 1, 584, 1'b1, 1'b0, 0);
        tv[4]  = mkv(1'b1, 1'b1, 1'b0, 2, 0,   1'b1, 1'b0, 0);
        tv[5]  = mkv(1'b1, 1'b1, 1'b1, 2, 0,   1'b1, 1'b0, 0);
        tv[6]  = mkv(1'b1, 1'b1, 1'b0, 3, 22,  1'b1, 1'b0, 0);
        tv[7]  = mkv(1'b1, 1'b1, 1'b1, 3, 22,  1'b1, 1'b0, 0);
        tv[8]  = mkv(1'b1, 1'b0, 1'b0, 0, 0,   1'b1, 1'b0, 0);
        tv[9]  = mkv(1'b1, 1'b0, 1'b0, 0, 0,   1'b1, 1'b0, 0);
        tv[10] = mkv(1'b1, 1'b0, 1'b0, 0, 0,   1'b1, 1'b0, 0);
        tv[11] = mkv(1'b1, 1'b0, 1'b0, 0, 0,   1'b1, 1'b0, 0);
        tv[12] = mkv(1'b0, 1'b0, 1'b0, 0, 0,   1'b0, 1'b1, 1);

        // ---- reset state ----
        drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        rst_a = 1'b1; rst_b = 1'b1;
        repeat (3) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0;
        check("reset_out_a", 64'(obs(1'b0)), 64'(pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0)));
        check("reset_cnt_a", 64'(cnt_a), 64'd0);
        check("reset_out_b", 64'(obs(1'b1)), 64'(pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0)));
        check("reset_cnt_b", 64'(cnt_b), 64'd0);

        // ---- table: reference request, inputs scrambled while busy ----
        drive(1'b0, 1'b1, 32'd0, 32'd584, 32'd0, 32'd22);
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d_out", i + 1), 64'(obs(1'b0)),
                  64'(pk(~tv[i].busy, tv[i].busy, tv[i].done, tv[i].cs, tv[i].wr,
                         tv[i].addr, tv[i].data)));
            check($sformatf("vec%0d_cnt", i + 1), 64'(cnt_a), 64'(tv[i].cnt));
            drive(1'b0, tv[i].valid, $urandom, $urandom, $urandom, $urandom);
        end
        $display("table request done, done_count=%0d", cnt_a);
        @(negedge clk);
        check("no_extra_accept", 64'(obs(1'b0)), 64'(pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0)));

        // ---- reset during the write of register 2 ----
        drive(1'b0, 1'b1, 32'h11, 32'h22, 32'h33, 32'h44);
        for (int off = 1; off <= 6; off++) begin
            @(negedge clk);
            if (off == 1) drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        end
        check("mid_wr_idx2", 64'({ifa.slave_write, ifa.slave_address}), 64'({1'b1, 3'd2}));
        rst_a = 1'b1;
        @(negedge clk);
        rst_a = 1'b0;
        check("mid_rst_out", 64'(obs(1'b0)), 64'(pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0)));
        check("mid_rst_cnt", 64'(cnt_a), 64'd0);
        w3cnt = 0;
        repeat (14) begin
            @(negedge clk);
            if (ifa.slave_chipselect || ifa.slave_write || done_a) w3cnt++;
        end
        check("mid_rst_no_more_activity", 64'(w3cnt), 64'd0);
        $display("mid-sequence reset request abandoned");

        // ---- back-to-back requests ----
        exp_w[0] = 32'hA0; exp_w[1] = 32'hA1; exp_w[2] = 32'hA2; exp_w[3] = 32'hA3;
        exp_w[4] = 32'hB0; exp_w[5] = 32'hB1; exp_w[6] = 32'hB2; exp_w[7] = 32'hB3;
        drive(1'b0, 1'b1, exp_w[0], exp_w[1], exp_w[2], exp_w[3]);
        busy_cyc = 0; dones = 0; after_first = 1'b0;
        for (int c = 0; c < 80 && dones < 2; c++) begin
            @(negedge clk);
            if (c == 0) drive(1'b0, 1'b1, exp_w[4], exp_w[5], exp_w[6], exp_w[7]);
            if (after_first) begin
                check("b2b_restart_busy", 64'(busy_a), 64'd1);
                after_first = 1'b0;
            end
            if (busy_a) busy_cyc++;
            if (ifa.slave_write) wq.push_back(ifa.slave_writedata);
            if (done_a) begin
                dones++;
                if (dones == 1) begin
                    check("b2b_ready_in_done", 64'(ifa.req_ready), 64'd1);
                    after_first = 1'b1;
                end else begin
                    drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
                end
            end
        end
        check("b2b_dones", 64'(dones), 64'd2);
        check("b2b_busy_cycles", 64'(busy_cyc), 64'd24);
        check("b2b_cnt", 64'(cnt_a), 64'd2);
        check("b2b_nwrites", 64'(wq.size()), 64'd8);
        for (int i = 0; i < 8 && i < wq.size(); i++)
            check($sformatf("b2b_wdata%0d", i), 64'(wq[i]), 64'(exp_w[i]));
        $display("back-to-back pair done, busy=%0d", busy_cyc);

        // ---- done_count wrap ----
        force dut_a.r_done_cnt = 16'hFFFF;
        @(negedge clk);
        release dut_a.r_done_cnt;
        @(negedge clk);
        check("wrap_preload", 64'(cnt_a), 64'hFFFF);
        drive(1'b0, 1'b1, 32'h5, 32'h6, 32'h7, 32'h8);
        got = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (c == 0) drive(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
            if (done_a) got = 1'b1;
        end
        check("wrap_done_seen", 64'(got), 64'd1);
        check("wrap_cnt", 64'(cnt_a), 64'h0000);
        $display("wrap request done, done_count=%0d", cnt_a);

        // ---- zero setup / zero gap ----
        bw[0] = 32'hDEAD0000; bw[1] = 32'h00001234; bw[2] = 32'hFFFFFFFF; bw[3] = 32'h0000C0DE;
        drive(1'b1, 1'b1, bw[0], bw[1], bw[2], bw[3]);
        for (int off = 1; off <= 4; off++) begin
            @(negedge clk);
            if (off == 1) drive(1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
            check($sformatf("b_wr%0d", off - 1), 64'(obs(1'b1)),
                  64'(pk(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'(off - 1), bw[off - 1])));
        end
        @(negedge clk);
        check("b_done", 64'(obs(1'b1)), 64'(pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 32'd0)));
        check("b_cnt", 64'(cnt_b), 64'd1);
        $display("zero-setup request done");

        // ---- random against timeline model ----
        run_random(1'b0, SA, GA, 400);
        run_random(1'b1, SB, GB, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/slave_cfg_sequencer.md
SLAVE_CFG_SEQUENCER -- requirements
Module: slave_cfg_sequencer

Interface
REQ-001 Parameter SETUP_CYC, default 1: cycles chipselect/address/data are presented before slave_write asserts; legal range 0..15.
REQ-002 Parameter GAP_CYC, default 4: idle cycles with chipselect low after the final register write; legal range 0..15.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  sequencer can accept a request.
REQ-007 req_base  in  32  value for slave register 0.
REQ-008 req_len  in  32  value for slave register 1.
REQ-009 req_mode  in  32  value for slave register 2.
REQ-010 req_cmd  in  32  value for slave register 3 (command/trigger register).
REQ-011 slave_chipselect  out  1  Avalon-MM slave chipselect to the downstream master/slave block.
REQ-012 slave_write  out  1  Avalon-MM write strobe.
REQ-013 slave_address  out  3  register index.
REQ-014 slave_writedata  out  32  register write data.
REQ-015 busy  out  1  high whenever state is not IDLE.
REQ-016 seq_done  out  1  one-cycle pulse on completion of a request.
REQ-017 done_count  out  16  number of completed requests.

Function
REQ-018 Handshake: req_ready = (state == IDLE); transfer on the rising edge where req_valid && req_ready; all four req_* words are captured into holding registers at that edge.
REQ-019 While busy, req_valid is ignored and req_* inputs have no effect on outputs.
REQ-020 FSM states: IDLE, SETUP, WRITE, GAP.
REQ-021 IDLE -> SETUP on accept (idx = 0); chipselect asserts in the cycle after the accept edge.
REQ-022 SETUP: chipselect=1, slave_write=0, address=idx, writedata=held word[idx]; stay SETUP_CYC cycles, then -> WRITE; with SETUP_CYC=0, SETUP is skipped (IDLE/WRITE -> WRITE directly).
REQ-023 WRITE: chipselect=1, slave_write=1 for exactly one cycle, address/data unchanged from SETUP; then idx<3 -> idx+1, SETUP; idx==3 -> GAP (or IDLE if GAP_CYC=0).
REQ-024 Chipselect stays high continuously from the first SETUP to the last WRITE; address/data change only on SETUP entry.
REQ-025 GAP: chipselect=0, slave_write=0 for GAP_CYC cycles, then -> IDLE.
REQ-026 seq_done pulses in the first IDLE cycle after completion; done_count increments in that same cycle, wrapping 0xFFFF -> 0x0000.
REQ-027 Back-to-back: req_ready is high in the seq_done cycle; a request accepted there starts immediately.
REQ-028 Busy duration per request: 4*(SETUP_CYC+1)+GAP_CYC cycles.
REQ-029 In IDLE: chipselect=0, slave_write=0, address=0, writedata=0.

Reset
REQ-030 reset sampled high at any edge, including mid-sequence: state=IDLE, idx=0, holding registers=0, all outputs 0 except req_ready=1; done_count=0; no seq_done pulse; the in-progress sequence is abandoned with no further writes.

Structure
REQ-031 Package cfg_seq_pkg holds the state enum, NUM_REGS=4, and register index constants REG_BASE=0, REG_LEN=1, REG_MODE=2, REG_CMD=3.
REQ-032 The SETUP and GAP cycle counters are one instance each of sub-module flex_counter (loadable 4-bit counter with rollover flag).

Verification
REQ-033 SETUP_CYC=1, GAP_CYC=4; accept at edge k with base=0, len=584, mode=0, cmd=22 -> writes (addr,data) (0,0),(1,584),(2,0),(3,22) with slave_write high at cycles k+2, k+4, k+6, k+8; seq_done at k+13; done_count=1.
REQ-034 req_valid held high and req_* changed every cycle during busy -> no additional accept and written data equals the words captured at accept.
REQ-035 reset asserted during the WRITE of idx 2 -> next cycle all outputs 0, req_ready=1, done_count=0, and no address-3 write occurs.
REQ-036 Two back-to-back requests -> the second is accepted in the seq_done cycle; 24 busy cycles total; done_count=2.
REQ-037 SETUP_CYC=0, GAP_CYC=0 -> slave_write is high on four consecutive cycles at addresses 0..3; seq_done follows on the next cycle.
REQ-038 done_count preloaded by forcing to 0xFFFF, one request completed -> done_count=0x0000.
